bsram_sync_ctrl: RTL
====================

Name: bsram_sync_ctrl

Overview:
- Sequences backup-RAM (BSRAM) transfers between the on-chip BSRAM dual-port buffer and the mounted save file on SD, one 512-byte sector per transaction.
- Handles explicit load and save requests from the OSD, and the automatic load after a ROM download completes.
- Tracks which sectors the emulated CPU has written (dirty bitmap), so an optional autosave writes back only modified sectors after a write-idle timeout.
- Sits between the hps_io SD-sector interface and the BSRAM port-B sector addressing.

Parameters:
- SECT_AW, 8, width of the sector index; 2^SECT_AW sectors = 128 KB of BSRAM.
- IDLE_TIMEOUT, 21477270, clk_sys cycles with no BSRAM write before autosave starts (about 1 s).

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- bk_ena  in  1  save file mounted and writable; gates all requests
- ram_mask  in  24  BSRAM byte mask; last sector = ram_mask[23:9]
- load_req  in  1  level from OSD; rising edge requests a full load
- save_req  in  1  level from OSD; rising edge requests a full save
- dl_done  in  1  one-cycle pulse when ROM download ends
- autosave_en  in  1  enables timeout-driven dirty-sector save
- bsram_we  in  1  CPU write strobe to BSRAM (one cycle per byte)
- bsram_addr  in  17  CPU BSRAM byte address
- sd_lba  out  32  sector number; upper bits zero, [SECT_AW-1:0] = current index
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  hps_io transfer acknowledge
- busy  out  1  high whenever state is not IDLE
- loading  out  1  high for the whole load operation; system reset OR's this in
- dirty  out  1  OR of all dirty bits

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, busy=0, loading=0. Dirty bitmap cleared. Timer=0. State=IDLE. Edge-detect history is set to the current load_req/save_req, so a level that is already high at reset is not treated as an edge.
- Dirty tracking:
  - Every cycle with bsram_we=1 sets bit bsram_addr[16:9] and reloads the timer to 0.
  - The timer increments, saturating at IDLE_TIMEOUT, while any bit is dirty.
  - A write in the same cycle as a clear of the same bit wins: the bit stays set.
- Request priority, sampled only in IDLE and only when bk_ena=1:
  - dl_done or load_req rising edge → LOAD (full).
  - otherwise save_req rising edge → SAVE (full).
  - otherwise autosave_en & dirty & timer==IDLE_TIMEOUT → SAVE (dirty-only).
  - Edges arriving while not IDLE are dropped (edge history still updates).
- States:
  - IDLE: waits for a request; on accept sets idx=0 and goes to SCAN.
  - SCAN: one index per cycle.
    - If idx > ram_mask[23:9] → IDLE.
    - Else if the mode is LOAD, full SAVE, or the bit for idx is set → REQ.
    - Else idx+1, stay in SCAN.
  - REQ:
    - sd_lba=idx.
    - Asserts sd_rd (LOAD) or sd_wr (SAVE) from this cycle onward.
    - For SAVE, clears dirty bit idx in this cycle.
    - → WAIT_ACK.
  - WAIT_ACK: on sd_ack rising edge, deasserts sd_rd/sd_wr in the next cycle → WAIT_DONE.
  - WAIT_DONE: on sd_ack falling edge, idx+1 → SCAN.
- sd_rd and sd_wr are never high together. At most one sector is outstanding.
- loading rises on the cycle LOAD is accepted and falls when SCAN exits to IDLE. On LOAD completion the whole bitmap is cleared and the timer is zeroed.
- A CPU write during a SAVE to a sector already cleared re-sets its bit; the next autosave picks it up. Writes during LOAD still set bits; the bitmap is then cleared at completion.
- If bk_ena falls mid-operation, the current operation finishes normally.
- ram_mask is sampled once into a register at request accept. Later changes do not affect the current operation.
- Sector index width: the comparison uses ram_mask[9+SECT_AW-1:9]. If the masked value exceeds 2^SECT_AW-1, it is clamped to 2^SECT_AW-1.
- If RESET is asserted mid-transfer: immediate return to IDLE with all reset values, even if sd_ack is high. A later sd_ack falling edge is ignored in IDLE.

Test Plan:
- Reset with load_req held high, then bk_ena=1 and ram_mask=0x1FFF → no transfer starts; busy=0.
- Full load: pulse dl_done, ram_mask=0x1FFF → 16 reads with sd_lba 0..15, loading high throughout and low one cycle after the last ack falls, dirty=0 at the end.
- Full save: save_req edge, ram_mask=0x07FF → exactly 4 sd_wr requests with sd_lba 0..3. sd_wr drops one cycle after each sd_ack rise; sd_rd stays 0.
- Autosave: writes to addr 0x00200 and 0x01A05, autosave_en=1, IDLE_TIMEOUT=100 → after 100 idle cycles, writes to sd_lba 1 then 13 only; dirty=0 afterwards.
- Simultaneous events, in a cycle with save_req edge plus dl_done → LOAD is chosen. A CPU write to sector 2 during its REQ cycle leaves dirty=1 after the save.
- RESET asserted while sd_ack=1 in WAIT_DONE → next cycle sd_wr=0, busy=0, sd_lba=0. A save_req edge after that runs a fresh save starting at lba 0.

Source files
------------

// File: rtl/bsram_sync_ctrl_if.sv
// SD-sector handshake between the BSRAM sync controller and hps_io.
// The controller requests one sector at a time; hps_io acknowledges with an sd_ack pulse.
interface bsram_sync_ctrl_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/bsram_sync_ctrl.sv
// Moves BSRAM contents to/from the SD save file one 512-byte sector at a time,
// tracking CPU-dirtied sectors so autosave only writes back what changed.
module bsram_sync_ctrl #(
  parameter int SECT_AW      = 8,
  parameter int IDLE_TIMEOUT = 21477270
) (
  input  logic                    clk_sys,
  input  logic                    RESET,
  input  logic                    bk_ena,
  input  logic [23:0]             ram_mask,
  input  logic                    load_req,
  input  logic                    save_req,
  input  logic                    dl_done,
  input  logic                    autosave_en,
  input  logic                    bsram_we,
  input  logic [16:0]             bsram_addr,
  bsram_sync_ctrl_if.master       sd,
  output logic                    busy,
  output logic                    loading,
  output logic                    dirty
);

  localparam int NSECT = 1 << SECT_AW;
  localparam int IW    = SECT_AW + 1;
  localparam int TW    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT_ACK, WAIT_DONE} state_t;

  state_t state, state_nxt;

  // idx carries one extra bit so it can step past a last sector of 2^SECT_AW-1
  logic [IW-1:0]      idx, idx_nxt;
  logic [IW-1:0]      last, last_nxt, last_cand;
  logic               mode_load, mode_load_nxt;
  logic               mode_full, mode_full_nxt;
  logic [SECT_AW-1:0] lba_q, lba_nxt;
  logic               rd_q, rd_nxt;
  logic               wr_q, wr_nxt;
  logic               loading_q, loading_nxt;
  logic               clr_one, clr_all;

  logic [NSECT-1:0]   dirty_map, dirty_map_nxt;
  logic [TW-1:0]      timer;
  logic               dirty_any;

  logic               load_hist, save_hist, ack_hist;
  logic               load_edge, save_edge, ack_rise, ack_fall;
  logic [14:0]        mask_sect;
  logic [SECT_AW-1:0] wr_sect;
  logic               unused_bits;

  assign mask_sect = ram_mask[23:9];
  assign wr_sect   = bsram_addr[9+SECT_AW-1:9];
  assign last_cand = (mask_sect > 15'(NSECT - 1)) ? IW'(NSECT - 1)
                                                  : {1'b0, mask_sect[SECT_AW-1:0]};

  assign load_edge = load_req & ~load_hist;
  assign save_edge = save_req & ~save_hist;
  assign ack_rise  = sd.sd_ack & ~ack_hist;
  assign ack_fall  = ~sd.sd_ack & ack_hist;
  assign dirty_any = |dirty_map;

  assign sd.sd_lba = {{(32-SECT_AW){1'b0}}, lba_q};
  assign sd.sd_rd  = rd_q;
  assign sd.sd_wr  = wr_q;
  assign busy      = (state != IDLE);
  assign loading   = loading_q;
  assign dirty     = dirty_any;

  assign unused_bits = ^{ram_mask[8:0], bsram_addr[8:0]};

  // Edge history follows the inputs even during reset, so a level already high is not an edge
  always_ff @(posedge clk_sys) begin
    load_hist <= load_req;
    save_hist <= save_req;
    ack_hist  <= sd.sd_ack;
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state     <= IDLE;
      idx       <= '0;
      last      <= '0;
      mode_load <= 1'b0;
      mode_full <= 1'b0;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      loading_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      last      <= last_nxt;
      mode_load <= mode_load_nxt;
      mode_full <= mode_full_nxt;
      lba_q     <= lba_nxt;
      rd_q      <= rd_nxt;
      wr_q      <= wr_nxt;
      loading_q <= loading_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    last_nxt      = last;
    mode_load_nxt = mode_load;
    mode_full_nxt = mode_full;
    lba_nxt       = lba_q;
    rd_nxt        = rd_q;
    wr_nxt        = wr_q;
    loading_nxt   = loading_q;
    clr_one       = 1'b0;
    clr_all       = 1'b0;

    case (state)
      IDLE: begin
        if (bk_ena) begin
          if (dl_done || load_edge) begin
            state_nxt     = SCAN;
            idx_nxt       = '0;
            last_nxt      = last_cand;
            mode_load_nxt = 1'b1;
            mode_full_nxt = 1'b1;
            loading_nxt   = 1'b1;
          end else if (save_edge) begin
            state_nxt     = SCAN;
            idx_nxt       = '0;
            last_nxt      = last_cand;
            mode_load_nxt = 1'b0;
            mode_full_nxt = 1'b1;
          end else if (autosave_en && dirty_any && (timer == TMAX)) begin
            state_nxt     = SCAN;
            idx_nxt       = '0;
            last_nxt      = last_cand;
            mode_load_nxt = 1'b0;
            mode_full_nxt = 1'b0;
          end
        end
      end
      SCAN: begin
        if (idx > last) begin
          state_nxt = IDLE;
          if (mode_load) begin
            loading_nxt = 1'b0;
            clr_all     = 1'b1;
          end
        end else if (mode_full || dirty_map[idx[SECT_AW-1:0]]) begin
          state_nxt = REQ;
          lba_nxt   = idx[SECT_AW-1:0];
          rd_nxt    = mode_load;
          wr_nxt    = ~mode_load;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      REQ: begin
        state_nxt = WAIT_ACK;
        clr_one   = ~mode_load;
      end
      WAIT_ACK: begin
        if (ack_rise) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (ack_fall) begin
          idx_nxt   = idx + 1'b1;
          state_nxt = SCAN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A CPU write in the same cycle as a clear keeps its bit set
  always_comb begin
    dirty_map_nxt = dirty_map;
    if (clr_all)
      dirty_map_nxt = '0;
    else if (clr_one)
      dirty_map_nxt = dirty_map & ~(NSECT'(1) << idx[SECT_AW-1:0]);
    if (bsram_we)
      dirty_map_nxt = dirty_map_nxt | (NSECT'(1) << wr_sect);
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      dirty_map <= '0;
      timer     <= '0;
    end else begin
      dirty_map <= dirty_map_nxt;
      if (bsram_we || clr_all)
        timer <= '0;
      else if (dirty_any && (timer != TMAX))
        timer <= timer + 1'b1;
    end
  end

endmodule
